// File: rtl/ccip_nic_transmitter_if.sv
// ccip_nic_transmitter_if: CCI-P subset types and the RPC / c1 write bus of the NIC transmitter.
package ccip_nic_pkg;
    localparam int LMAX_CCIP_BATCH = 5;
    typedef logic [41:0] t_ccip_clAddr;
    typedef logic [511:0] t_ccip_clData;
    typedef enum logic [1:0] {eVC_VA = 2'd0, eVC_VL0 = 2'd1, eVC_VH0 = 2'd2, eVC_VH1 = 2'd3} t_ccip_vc;
    typedef enum logic [1:0] {eCL_LEN_1 = 2'd0, eCL_LEN_2 = 2'd1, eCL_LEN_4 = 2'd3} t_ccip_clLen;
    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;
    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;
    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;
    typedef struct packed {
        logic [31:0] rpc_id;
        logic [31:0] fn_id;
        logic [63:0] argl;
        logic [63:0] argv;
    } RpcIf;
endpackage

interface ccip_nic_transmitter_if import ccip_nic_pkg::*; #(parameter int LMAX_NUM_OF_FLOWS = 1);
    RpcIf                         rpc_in;
    logic                         rpc_in_valid;
    logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in;
    logic                         ccip_tx_ready;
    logic                         sRx_c1TxAlmFull;
    t_if_ccip_c1_Tx               sTx_c1;
    modport master(output rpc_in, rpc_in_valid, rpc_flow_id_in, sRx_c1TxAlmFull, input ccip_tx_ready, sTx_c1);
    modport slave(input rpc_in, rpc_in_valid, rpc_flow_id_in, sRx_c1TxAlmFull, output ccip_tx_ready, sTx_c1);
endinterface

// File: rtl/ccip_nic_transmitter.sv
// ccip_nic_transmitter: writes each accepted RPC as one cache line into its flow's host ring buffer.
module single_clock_wr_ram #(
    parameter int DATA_WIDTH = 1,
    parameter int ADR_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADR_WIDTH-1:0]  read_address,
    input  logic [ADR_WIDTH-1:0]  write_address,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    logic [DATA_WIDTH-1:0] mem [2**ADR_WIDTH];
    // registered read; a same-address write in the same cycle returns the old word
    always_ff @(posedge clk) begin
        if (we) mem[write_address] <= d;
        q <= mem[read_address];
    end
endmodule

module ccip_nic_transmitter import ccip_nic_pkg::*; #(
    parameter int NIC_ID             = 0,
    parameter int LMAX_NUM_OF_FLOWS  = 1,
    parameter int LMAX_TX_QUEUE_SIZE = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [LMAX_NUM_OF_FLOWS-1:0]  number_of_flows,
    input  t_ccip_clAddr                  tx_base_addr,
    input  logic [LMAX_CCIP_BATCH-1:0]    l_tx_batch_size,
    input  logic [LMAX_TX_QUEUE_SIZE:0]   tx_queue_size,
    input  logic                          start,
    input  logic                          initialize,
    output logic                          initialized,
    output logic                          error,
    input  logic                          lb_select,
    output logic                          pdrop_tx_flows_out,
    output logic [63:0]                   debug_out,
    ccip_nic_transmitter_if.slave         bus
);
    localparam int LF = LMAX_NUM_OF_FLOWS;
    localparam int LQ = LMAX_TX_QUEUE_SIZE;
    localparam logic [LQ:0] QMAX = {1'b1, {LQ{1'b0}}};

    if (NIC_ID < 0) begin : g_bad_nic_id
        $error("ccip_nic_transmitter: NIC_ID must be non-negative");
    end

    typedef enum logic {IDLE, CLEAR} t_state;
    t_state             state;
    logic [LF-1:0]      init_addr;
    logic               accept, bad_cfg;
    logic               s1_valid, s3_valid;
    logic [LF-1:0]      s1_flow, s2_flow, s3_flow;
    RpcIf               s1_rpc;
    t_ccip_vc           s1_vc;
    logic [LQ-1:0]      q, slot, next, s2_next, s3_next;
    logic [LQ:0]        slot_inc;
    logic               ram_we;
    logic [LF-1:0]      ram_wa;
    logic [LQ-1:0]      ram_d;
    t_ccip_c1_ReqMemHdr hdr;

    assign bus.ccip_tx_ready = initialized & start & ~bus.sRx_c1TxAlmFull;
    assign accept = bus.rpc_in_valid & bus.ccip_tx_ready & (bus.rpc_flow_id_in <= number_of_flows);
    assign bad_cfg = (tx_queue_size == '0) || (tx_queue_size > QMAX)
                   || ((32'd1 << l_tx_batch_size) > 32'(tx_queue_size));

    // the clear sequence owns the write port; otherwise stage 2 stores the advanced pointer
    assign ram_we = (state == CLEAR) | bus.sTx_c1.valid;
    assign ram_wa = (state == CLEAR) ? init_addr : s2_flow;
    assign ram_d  = (state == CLEAR) ? '0 : s2_next;

    single_clock_wr_ram #(.DATA_WIDTH(LQ), .ADR_WIDTH(LF)) ptr_ram (
        .clk           (clk),
        .we            (ram_we),
        .read_address  (bus.rpc_flow_id_in),
        .write_address (ram_wa),
        .d             (ram_d),
        .q             (q)
    );

    // slot comes from the newest in-flight pointer of the same flow: stage 2 is not yet written,
    // and the entry written last cycle collided with our read, which returned the stale word
    always_comb begin
        slot = (bus.sTx_c1.valid && s2_flow == s1_flow) ? s2_next :
               (s3_valid && s3_flow == s1_flow) ? s3_next : q;
        slot_inc = {1'b0, slot} + (LQ+1)'(1);
        next = (slot_inc == tx_queue_size) ? '0 : slot_inc[LQ-1:0];
        hdr = '0;
        hdr.vc_sel = s1_vc;
        hdr.sop = 1'b1;
        hdr.cl_len = eCL_LEN_1;
        hdr.req_type = eREQ_WRLINE_I;
        hdr.address = tx_base_addr + (t_ccip_clAddr'(s1_flow) << LQ) + t_ccip_clAddr'(slot);
    end

    // pointer-table clear: one address per cycle, then initialized stays set until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            init_addr <= '0;
            initialized <= 1'b0;
        end else if (state == IDLE) begin
            if (initialize && !initialized) begin
                state <= CLEAR;
                init_addr <= '0;
            end
        end else if (&init_addr) begin
            state <= IDLE;
            initialized <= 1'b1;
        end else begin
            init_addr <= init_addr + LF'(1);
        end
    end

    // sticky flag for an unusable ring configuration while enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) error <= 1'b0;
        else if (start && bad_cfg) error <= 1'b1;
    end

    // three-stage write pipeline plus drop pulse and issued-line counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_flow <= '0;
            s1_rpc <= '0;
            s1_vc <= eVC_VH0;
            s2_flow <= '0;
            s2_next <= '0;
            s3_valid <= 1'b0;
            s3_flow <= '0;
            s3_next <= '0;
            bus.sTx_c1 <= '0;
            pdrop_tx_flows_out <= 1'b0;
            debug_out <= '0;
        end else begin
            s1_valid <= accept;
            s1_flow <= bus.rpc_flow_id_in;
            s1_rpc <= bus.rpc_in;
            s1_vc <= lb_select ? eVC_VL0 : eVC_VH0;
            bus.sTx_c1.valid <= s1_valid;
            bus.sTx_c1.hdr <= hdr;
            bus.sTx_c1.data <= t_ccip_clData'(s1_rpc);
            s2_flow <= s1_flow;
            s2_next <= next;
            s3_valid <= bus.sTx_c1.valid;
            s3_flow <= s2_flow;
            s3_next <= s2_next;
            pdrop_tx_flows_out <= bus.rpc_in_valid & ~accept;
            debug_out <= debug_out + 64'(bus.sTx_c1.valid);
        end
    end
endmodule

// File: tb/tb_ccip_nic_transmitter.sv
// tb_ccip_nic_transmitter: scoreboard bench for the CCI-P NIC transmitter.
module tb_ccip_nic_transmitter;
    import ccip_nic_pkg::*;
    localparam int LF = 2;
    localparam int LQ = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [LF-1:0]        number_of_flows;
    t_ccip_clAddr         tx_base_addr;
    logic [LMAX_CCIP_BATCH-1:0] l_tx_batch_size;
    logic [LQ:0]          tx_queue_size;
    logic                 start, initialize, initialized, error, lb_select, pdrop_tx_flows_out;
    logic [63:0]          debug_out;

    ccip_nic_transmitter_if #(.LMAX_NUM_OF_FLOWS(LF)) bus();

    ccip_nic_transmitter #(.NIC_ID(0), .LMAX_NUM_OF_FLOWS(LF), .LMAX_TX_QUEUE_SIZE(LQ)) dut (
        .clk                (clk),
        .reset              (reset),
        .number_of_flows    (number_of_flows),
        .tx_base_addr       (tx_base_addr),
        .l_tx_batch_size    (l_tx_batch_size),
        .tx_queue_size      (tx_queue_size),
        .start              (start),
        .initialize         (initialize),
        .initialized        (initialized),
        .error              (error),
        .lb_select          (lb_select),
        .pdrop_tx_flows_out (pdrop_tx_flows_out),
        .debug_out          (debug_out),
        .bus                (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        t_ccip_clAddr addr;
        t_ccip_clData data;
        t_ccip_vc     vc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            pass_cnt = 0;
    int            total_cnt = 0;
    logic [LQ-1:0] ptr [4];
    longint        dbg_exp = 0;

    // scoreboard: every issued line must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && bus.sTx_c1.valid) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%h, required no write", bus.sTx_c1.hdr.address);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.sTx_c1.hdr.address !== mon_e.addr || bus.sTx_c1.data !== mon_e.data ||
                    bus.sTx_c1.hdr.vc_sel !== mon_e.vc || bus.sTx_c1.hdr.req_type !== eREQ_WRLINE_I ||
                    bus.sTx_c1.hdr.sop !== 1'b1 || bus.sTx_c1.hdr.cl_len !== eCL_LEN_1 ||
                    bus.sTx_c1.hdr.mdata !== 16'h0)
                    $display("FAIL write: got addr=%h vc=%0d type=%0d sop=%b len=%0d data=%h, required addr=%h vc=%0d type=0 sop=1 len=0 data=%h",
                             bus.sTx_c1.hdr.address, bus.sTx_c1.hdr.vc_sel, bus.sTx_c1.hdr.req_type,
                             bus.sTx_c1.hdr.sop, bus.sTx_c1.hdr.cl_len, bus.sTx_c1.data[191:0],
                             mon_e.addr, mon_e.vc, mon_e.data[191:0]);
                else pass_cnt++;
            end
        end
    end

    task automatic push(input int flow, input RpcIf r);
        exp_t e;
        int   nx;
        e.addr = tx_base_addr + t_ccip_clAddr'(flow * (1 << LQ)) + t_ccip_clAddr'(ptr[flow]);
        e.data = '0;
        e.data[$bits(RpcIf)-1:0] = r;
        e.vc = lb_select ? eVC_VL0 : eVC_VH0;
        exp_q.push_back(e);
        nx = int'(ptr[flow]) + 1;
        ptr[flow] = (nx == int'(tx_queue_size)) ? '0 : nx[LQ-1:0];
        dbg_exp++;
    endtask

    task automatic drive(input int flow, input bit acc);
        RpcIf r;
        r = '{rpc_id: $urandom, fn_id: $urandom, argl: {$urandom, $urandom}, argv: {$urandom, $urandom}};
        bus.rpc_in = r;
        bus.rpc_in_valid = 1'b1;
        bus.rpc_flow_id_in = flow[LF-1:0];
        if (acc) push(flow, r);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        bus.rpc_in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        dbg_exp = 0;
    endtask

    task automatic do_init(output int cyc);
        initialize = 1'b1;
        @(posedge clk); #1;
        initialize = 1'b0;
        cyc = 1;
        while (!initialized && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        for (int i = 0; i < 4; i++) ptr[i] = '0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total_cnt++; if (bus.sTx_c1.valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", bus.sTx_c1.valid); else pass_cnt++;
        total_cnt++; if (initialized !== 1'b0) $display("FAIL reset_initialized: got %b, required 0", initialized); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL reset_error: got %b, required 0", error); else pass_cnt++;
        total_cnt++; if (pdrop_tx_flows_out !== 1'b0) $display("FAIL reset_pdrop: got %b, required 0", pdrop_tx_flows_out); else pass_cnt++;
        total_cnt++; if (debug_out !== 64'd0) $display("FAIL reset_debug: got %0d, required 0", debug_out); else pass_cnt++;
        total_cnt++; if (bus.ccip_tx_ready !== 1'b0) $display("FAIL reset_ready: got %b, required 0", bus.ccip_tx_ready); else pass_cnt++;
    endtask

    task automatic test_init;
        int cyc;
        start = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (bus.ccip_tx_ready !== 1'b0) $display("FAIL ready_before_init: got %b, required 0", bus.ccip_tx_ready); else pass_cnt++;
        do_init(cyc);
        total_cnt++; if (cyc !== 5) $display("FAIL init_latency: got %0d edges, required 5", cyc); else pass_cnt++;
        total_cnt++; if (bus.ccip_tx_ready !== 1'b1) $display("FAIL ready_after_init: got %b, required 1", bus.ccip_tx_ready); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL init_error: got %b, required 0", error); else pass_cnt++;
    endtask

    task automatic test_single_write;
        drive(1, 1'b1);
        bus.rpc_in_valid = 1'b0;
        total_cnt++; if (bus.sTx_c1.valid !== 1'b0) $display("FAIL single_early: got valid %b one cycle after accept, required 0", bus.sTx_c1.valid); else pass_cnt++;
        total_cnt++; if (pdrop_tx_flows_out !== 1'b0) $display("FAIL single_pdrop: got %b, required 0", pdrop_tx_flows_out); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (bus.sTx_c1.valid !== 1'b1) $display("FAIL single_latency: got valid %b two cycles after accept, required 1", bus.sTx_c1.valid); else pass_cnt++;
        wait_drain("single");
        total_cnt++; if (debug_out !== 64'd1) $display("FAIL single_debug: got %0d, required 1", debug_out); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 9; i++) drive(0, 1'b1);
        wait_drain("back_to_back");
    endtask

    task automatic test_interleave;
        int flows[10] = '{0, 1, 0, 2, 2, 1, 0, 3, 0, 0};
        foreach (flows[i]) drive(flows[i], 1'b1);
        wait_drain("interleave");
        initialize = 1'b1;
        @(posedge clk); #1;
        initialize = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total_cnt++; if (initialized !== 1'b1) $display("FAIL reinit_initialized: got %b, required 1", initialized); else pass_cnt++;
        drive(0, 1'b1);
        drive(1, 1'b1);
        wait_drain("reinit_ignored");
    endtask

    task automatic test_drops;
        bus.sRx_c1TxAlmFull = 1'b1;
        #1;
        total_cnt++; if (bus.ccip_tx_ready !== 1'b0) $display("FAIL almfull_ready: got %b, required 0", bus.ccip_tx_ready); else pass_cnt++;
        drive(1, 1'b0);
        bus.rpc_in_valid = 1'b0;
        bus.sRx_c1TxAlmFull = 1'b0;
        total_cnt++; if (pdrop_tx_flows_out !== 1'b1) $display("FAIL almfull_pdrop: got %b, required 1", pdrop_tx_flows_out); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (pdrop_tx_flows_out !== 1'b0) $display("FAIL almfull_pdrop_width: got %b, required 0", pdrop_tx_flows_out); else pass_cnt++;
        number_of_flows = 2'd1;
        drive(3, 1'b0);
        bus.rpc_in_valid = 1'b0;
        total_cnt++; if (pdrop_tx_flows_out !== 1'b1) $display("FAIL badflow_pdrop: got %b, required 1", pdrop_tx_flows_out); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (pdrop_tx_flows_out !== 1'b0) $display("FAIL badflow_pdrop_width: got %b, required 0", pdrop_tx_flows_out); else pass_cnt++;
        drive(1, 1'b1);
        bus.rpc_in_valid = 1'b0;
        total_cnt++; if (pdrop_tx_flows_out !== 1'b0) $display("FAIL edgeflow_pdrop: got %b, required 0", pdrop_tx_flows_out); else pass_cnt++;
        number_of_flows = 2'd3;
        drive(2, 1'b1);
        start = 1'b0;
        wait_drain("drops");
        drive(2, 1'b0);
        bus.rpc_in_valid = 1'b0;
        total_cnt++; if (pdrop_tx_flows_out !== 1'b1) $display("FAIL stopped_pdrop: got %b, required 1", pdrop_tx_flows_out); else pass_cnt++;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_vc;
        lb_select = 1'b1;
        drive(2, 1'b1);
        drive(3, 1'b1);
        lb_select = 1'b0;
        drive(2, 1'b1);
        wait_drain("vc");
        total_cnt++; if (debug_out !== 64'(dbg_exp)) $display("FAIL debug_count: got %0d, required %0d", debug_out, dbg_exp); else pass_cnt++;
    endtask

    task automatic test_error;
        tx_queue_size = 4'd4;
        l_tx_batch_size = 5'd3;
        @(posedge clk); #1;
        total_cnt++; if (error !== 1'b1) $display("FAIL err_batch: got %b, required 1", error); else pass_cnt++;
        tx_queue_size = 4'd8;
        l_tx_batch_size = 5'd2;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (error !== 1'b1) $display("FAIL err_sticky: got %b, required 1", error); else pass_cnt++;
        do_reset;
        total_cnt++; if (error !== 1'b0) $display("FAIL err_reset: got %b, required 0", error); else pass_cnt++;
        tx_queue_size = 4'd9;
        l_tx_batch_size = 5'd0;
        @(posedge clk); #1;
        total_cnt++; if (error !== 1'b1) $display("FAIL err_too_deep: got %b, required 1", error); else pass_cnt++;
        do_reset;
        start = 1'b0;
        tx_queue_size = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (error !== 1'b0) $display("FAIL err_when_stopped: got %b, required 0", error); else pass_cnt++;
        start = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (error !== 1'b1) $display("FAIL err_zero_size: got %b, required 1", error); else pass_cnt++;
        do_reset;
        tx_queue_size = 4'd8;
        l_tx_batch_size = 5'd3;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (error !== 1'b0) $display("FAIL err_boundary_ok: got %b, required 0", error); else pass_cnt++;
        l_tx_batch_size = 5'd2;
    endtask

    task automatic test_reset_in_flight;
        int cyc;
        do_init(cyc);
        total_cnt++; if (initialized !== 1'b1) $display("FAIL rif_init: got %b after %0d edges, required 1", initialized, cyc); else pass_cnt++;
        drive(1, 1'b0);
        bus.rpc_in_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (bus.sTx_c1.valid !== 1'b1 || bus.sTx_c1.hdr.address !== 42'h1008)
            $display("FAIL rif_inflight: got valid=%b addr=%h, required valid=1 addr=1008", bus.sTx_c1.valid, bus.sTx_c1.hdr.address);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (bus.sTx_c1.valid !== 1'b0) $display("FAIL rif_valid: got %b, required 0", bus.sTx_c1.valid); else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        total_cnt++; if (initialized !== 1'b0) $display("FAIL rif_initialized: got %b, required 0", initialized); else pass_cnt++;
        total_cnt++; if (debug_out !== 64'd0) $display("FAIL rif_debug: got %0d, required 0", debug_out); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        number_of_flows = 2'd3;
        tx_base_addr = 42'h1000;
        l_tx_batch_size = 5'd2;
        tx_queue_size = 4'd8;
        start = 1'b0;
        initialize = 1'b0;
        lb_select = 1'b0;
        bus.rpc_in = '0;
        bus.rpc_in_valid = 1'b0;
        bus.rpc_flow_id_in = '0;
        bus.sRx_c1TxAlmFull = 1'b0;
        for (int i = 0; i < 4; i++) ptr[i] = '0;
        test_reset;
        test_init;
        test_single_write;
        test_back_to_back;
        test_interleave;
        test_drops;
        test_vc;
        test_error;
        test_reset_in_flight;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
